sva_busy_monitor: RTL and testbench

- Parametrised, synthesizable protocol monitor for the vsfx/pu issue interface.
- Generalises the fixed three-input "all go high implies busy" check. Supports:
  - N go lanes with a per-lane mask
  - AND/OR trigger mode
  - a bounded busy-response latency window
  - a busy-duration timeout
  - spurious-busy detection
- Provides saturating violation counters, sticky error flags and a simulation-only assertion hook.
- Sits beside the DUT in the functional simulation platform. It can also be kept in emulation builds.

---
 rtl/sva_mon_pkg.sv | 22 ++
 rtl/sva_sat_counter.sv | 27 ++
 rtl/sva_busy_monitor.sv | 207 ++++++++++++++++++++
 tb/tb_sva_busy_monitor.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sva_mon_pkg.sv
// Shared types for the busy-protocol monitor.
// FSM encoding, trigger modes and error codes.
package sva_mon_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    BUSY      = 2'd2,
    HUNG      = 2'd3
  } mon_state_e;

  localparam int MODE_ALL = 0;
  localparam int MODE_ANY = 1;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_LATE     = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_SPURIOUS = 2'd3
  } err_code_e;

endpackage

// File: rtl/sva_sat_counter.sv
// Saturating statistics counter.
// Clear wins over increment; holds at all-ones.
module sva_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/sva_busy_monitor.sv
// Issue-interface monitor: go lanes must be answered by busy
// within a latency window, and busy must not run forever.
module sva_busy_monitor
  import sva_mon_pkg::*;
#(
  parameter int NUM_GO     = 3,
  parameter int MODE       = 0,
  parameter int MAX_LAT    = 0,
  parameter int MAX_BUSY   = 64,
  parameter int CHK_SPUR   = 1,
  parameter int CNT_W      = 16,
  parameter int SIM_REPORT = 1
) (
  input  logic              sva_clk,
  input  logic              sva_rst_n,
  input  logic [NUM_GO-1:0] sva_go,
  input  logic [NUM_GO-1:0] sva_go_mask,
  input  logic              sva_dut_busy,
  input  logic              sva_chk_en,
  input  logic              sva_clr,
  output logic              err_late,
  output logic              err_timeout,
  output logic              err_spurious,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  trig_cnt,
  output logic [CNT_W-1:0]  viol_cnt,
  output logic [1:0]        mon_state
);

  localparam int LW = 4;
  localparam int BW = $clog2(MAX_BUSY + 1);

  mon_state_e r_state;
  mon_state_e w_nxt_state;
  logic [LW-1:0] r_lat_cnt;
  logic [LW-1:0] w_nxt_lat;
  logic [BW-1:0] r_busy_cnt;
  logic [BW-1:0] w_nxt_busy;
  logic r_busy_q;
  logic r_err_late;
  logic r_err_tmo;
  logic r_err_spur;
  logic r_sticky;
  logic w_trig;
  logic w_trig_acc;
  logic w_late;
  logic w_tmo;
  logic w_spur;
  logic w_viol;
  err_code_e w_err_code;

  always_comb begin
    w_trig = 1'b0;
    if (MODE == MODE_ANY) begin
      w_trig = |(sva_go & sva_go_mask);
    end else begin
      w_trig = (|sva_go_mask) & (&(sva_go | ~sva_go_mask));
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_lat   = r_lat_cnt;
    w_nxt_busy  = r_busy_cnt;
    w_trig_acc  = 1'b0;
    w_late      = 1'b0;
    w_tmo       = 1'b0;
    w_spur      = 1'b0;
    if (!sva_chk_en) begin
      w_nxt_state = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_trig) begin
            w_trig_acc = 1'b1;
            if (sva_dut_busy) begin
              w_nxt_state = BUSY;
              w_nxt_busy  = BW'(1);
            end else if (MAX_LAT == 0) begin
              w_late = 1'b1;
            end else begin
              w_nxt_state = WAIT_BUSY;
              w_nxt_lat   = LW'(1);
            end
          end else if (sva_dut_busy && !r_busy_q
                       && (CHK_SPUR != 0)) begin
            w_spur = 1'b1;
          end
        end
        WAIT_BUSY: begin
          if (sva_dut_busy) begin
            w_nxt_state = BUSY;
            w_nxt_busy  = BW'(1);
          end else if (r_lat_cnt == LW'(MAX_LAT)) begin
            w_late      = 1'b1;
            w_nxt_state = IDLE;
          end else begin
            w_nxt_lat = r_lat_cnt + LW'(1);
          end
        end
        BUSY: begin
          if (!sva_dut_busy) begin
            // A new issue may land on the very edge busy drops.
            w_nxt_state = IDLE;
            if (w_trig) begin
              w_trig_acc = 1'b1;
              if (MAX_LAT == 0) begin
                w_late = 1'b1;
              end else begin
                w_nxt_state = WAIT_BUSY;
                w_nxt_lat   = LW'(1);
              end
            end
          end else if (r_busy_cnt == BW'(MAX_BUSY)) begin
            w_tmo       = 1'b1;
            w_nxt_state = HUNG;
          end else begin
            w_nxt_busy = r_busy_cnt + BW'(1);
          end
        end
        HUNG: begin
          if (!sva_dut_busy) begin
            w_nxt_state = IDLE;
          end
        end
        default: w_nxt_state = IDLE;
      endcase
    end
  end

  assign w_viol = w_late | w_tmo | w_spur;

  always_ff @(posedge sva_clk or negedge sva_rst_n) begin
    if (!sva_rst_n) begin
      r_state    <= IDLE;
      r_lat_cnt  <= '0;
      r_busy_cnt <= '0;
      r_busy_q   <= 1'b0;
      r_err_late <= 1'b0;
      r_err_tmo  <= 1'b0;
      r_err_spur <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_lat_cnt  <= w_nxt_lat;
      r_busy_cnt <= w_nxt_busy;
      r_busy_q   <= sva_dut_busy;
      r_err_late <= w_late;
      r_err_tmo  <= w_tmo;
      r_err_spur <= w_spur;
    end
  end

  always_ff @(posedge sva_clk or negedge sva_rst_n) begin
    if (!sva_rst_n) begin
      r_sticky <= 1'b0;
    end else if (sva_clr) begin
      r_sticky <= 1'b0;
    end else if (w_viol) begin
      r_sticky <= 1'b1;
    end
  end

  sva_sat_counter #(.W(CNT_W)) u_trig_cnt (
    .clk   (sva_clk),
    .rst_n (sva_rst_n),
    .inc   (w_trig_acc),
    .clr   (sva_clr),
    .cnt   (trig_cnt)
  );

  sva_sat_counter #(.W(CNT_W)) u_viol_cnt (
    .clk   (sva_clk),
    .rst_n (sva_rst_n),
    .inc   (w_viol),
    .clr   (sva_clr),
    .cnt   (viol_cnt)
  );

  assign err_late     = r_err_late;
  assign err_timeout  = r_err_tmo;
  assign err_spurious = r_err_spur;
  assign err_sticky   = r_sticky;
  assign mon_state    = r_state;

  always_comb begin
    w_err_code = ERR_NONE;
    if (w_late) begin
      w_err_code = ERR_LATE;
    end else if (w_tmo) begin
      w_err_code = ERR_TIMEOUT;
    end else if (w_spur) begin
      w_err_code = ERR_SPURIOUS;
    end
  end

`ifndef SYNTHESIS
  always @(posedge sva_clk) begin
    if ((SIM_REPORT != 0) && sva_rst_n) begin
      assert (w_err_code == ERR_NONE)
      else $error("sva_busy_monitor: %s go=%b mask=%b state=%s",
                  w_err_code.name(), sva_go, sva_go_mask,
                  r_state.name());
    end
  end
`endif

endmodule

// File: tb/tb_sva_busy_monitor.sv
// Directed bench: three monitor instances with different
// parameter sets driven one at a time from a shared clock.
module tb_sva_busy_monitor;

  logic clk;
  logic rst_n;

  logic [2:0] a_go, a_mask, b_go, b_mask, c_go, c_mask;
  logic a_busy, a_en, a_clr;
  logic b_busy, b_en, b_clr;
  logic c_busy, c_en, c_clr;

  logic a_late, a_tmo, a_spur, a_stk;
  logic b_late, b_tmo, b_spur, b_stk;
  logic c_late, c_tmo, c_spur, c_stk;
  logic [15:0] a_trig, a_viol, b_trig, b_viol;
  logic [1:0] c_trig, c_viol;
  logic [1:0] a_st, b_st, c_st;

  int n_pass;
  int n_total;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sva_busy_monitor #(.SIM_REPORT(0)) u_a (
    .sva_clk(clk), .sva_rst_n(rst_n),
    .sva_go(a_go), .sva_go_mask(a_mask),
    .sva_dut_busy(a_busy), .sva_chk_en(a_en),
    .sva_clr(a_clr),
    .err_late(a_late), .err_timeout(a_tmo),
    .err_spurious(a_spur), .err_sticky(a_stk),
    .trig_cnt(a_trig), .viol_cnt(a_viol),
    .mon_state(a_st)
  );

  sva_busy_monitor #(
    .MAX_LAT(3), .MAX_BUSY(4), .SIM_REPORT(0)
  ) u_b (
    .sva_clk(clk), .sva_rst_n(rst_n),
    .sva_go(b_go), .sva_go_mask(b_mask),
    .sva_dut_busy(b_busy), .sva_chk_en(b_en),
    .sva_clr(b_clr),
    .err_late(b_late), .err_timeout(b_tmo),
    .err_spurious(b_spur), .err_sticky(b_stk),
    .trig_cnt(b_trig), .viol_cnt(b_viol),
    .mon_state(b_st)
  );

  sva_busy_monitor #(
    .MODE(1), .CNT_W(2), .SIM_REPORT(0)
  ) u_c (
    .sva_clk(clk), .sva_rst_n(rst_n),
    .sva_go(c_go), .sva_go_mask(c_mask),
    .sva_dut_busy(c_busy), .sva_chk_en(c_en),
    .sva_clr(c_clr),
    .err_late(c_late), .err_timeout(c_tmo),
    .err_spurious(c_spur), .err_sticky(c_stk),
    .trig_cnt(c_trig), .viol_cnt(c_viol),
    .mon_state(c_st)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    n_fail = 0;
    rst_n = 1'b0;
    a_go = '0; a_mask = '0; a_busy = 0; a_en = 1; a_clr = 0;
    b_go = '0; b_mask = '0; b_busy = 0; b_en = 1; b_clr = 0;
    c_go = '0; c_mask = '0; c_busy = 0; c_en = 1; c_clr = 0;
    #12;
    chk("rst_a_state", a_st, 0);
    chk("rst_a_err", {a_late, a_tmo, a_spur, a_stk}, 0);
    chk("rst_a_cnt", {a_trig, a_viol}, 0);
    chk("rst_c_cnt", {c_trig, c_viol}, 0);
    rst_n = 1'b1;
    tick();

    // Instance A: defaults, all lanes masked in
    a_mask = 3'b111; a_go = 3'b111; a_busy = 1;
    tick();
    chk("a_trig_busy_state", a_st, 2);
    chk("a_trig_busy_cnt", a_trig, 1);
    chk("a_trig_busy_noerr", a_late, 0);
    a_busy = 0;
    tick();
    chk("a_late_pulse", a_late, 1);
    chk("a_late_viol", a_viol, 1);
    chk("a_late_sticky", a_stk, 1);
    chk("a_late_trig", a_trig, 2);
    chk("a_late_state", a_st, 0);
    a_go = 3'b000;
    tick();
    chk("a_late_drop", a_late, 0);
    chk("a_sticky_hold", a_stk, 1);
    a_mask = 3'b000; a_go = 3'b111;
    tick();
    chk("a_mask0_trig", a_trig, 2);
    chk("a_mask0_late", a_late, 0);
    a_go = 3'b000; a_en = 0; a_busy = 1;
    tick();
    chk("a_dis_spur", a_spur, 0);
    a_en = 1;
    tick();
    chk("a_reen_spur", a_spur, 0);
    chk("a_reen_viol", a_viol, 1);
    a_busy = 0; a_clr = 1;
    tick();
    chk("a_clr_cnt", {a_trig, a_viol}, 0);
    chk("a_clr_sticky", a_stk, 0);
    a_clr = 0;

    // Instance B: latency window of 3
    b_mask = 3'b111; b_go = 3'b111;
    tick();
    chk("b_wait_state", b_st, 1);
    chk("b_wait_trig", b_trig, 1);
    b_go = 3'b000;
    tick();
    tick();
    chk("b_wait2_late", b_late, 0);
    b_busy = 1;
    tick();
    chk("b_lat3_state", b_st, 2);
    chk("b_lat3_late", b_late, 0);
    chk("b_lat3_viol", b_viol, 0);
    b_busy = 0;
    tick();
    chk("b_lat3_idle", b_st, 0);
    b_go = 3'b111;
    tick();
    b_go = 3'b000;
    tick();
    tick();
    chk("b_lat4_prelate", b_late, 0);
    tick();
    chk("b_lat4_late", b_late, 1);
    chk("b_lat4_state", b_st, 0);
    chk("b_lat4_viol", b_viol, 1);
    tick();
    chk("b_lat4_drop", b_late, 0);

    // Instance B: busy timeout of 4
    b_go = 3'b111; b_busy = 1;
    tick();
    b_go = 3'b000;
    tick();
    tick();
    tick();
    chk("b_tmo_pre", b_tmo, 0);
    chk("b_tmo_pre_state", b_st, 2);
    tick();
    chk("b_tmo_pulse", b_tmo, 1);
    chk("b_tmo_state", b_st, 3);
    chk("b_tmo_viol", b_viol, 2);
    tick();
    chk("b_hung_nopulse", b_tmo, 0);
    chk("b_hung_state", b_st, 3);
    b_busy = 0;
    tick();
    chk("b_hung_exit", b_st, 0);
    chk("b_tmo_trig", b_trig, 3);

    // Instance C: OR mode, lane 1 only, 2-bit counters
    c_mask = 3'b010; c_go = 3'b001;
    tick();
    chk("c_nolane_trig", c_trig, 0);
    chk("c_nolane_late", c_late, 0);
    c_go = 3'b010; c_busy = 1;
    tick();
    chk("c_any_trig", c_trig, 1);
    chk("c_any_state", c_st, 2);
    c_go = 3'b000; c_busy = 0;
    tick();
    chk("c_any_idle", c_st, 0);
    c_busy = 1;
    tick();
    chk("c_spur_pulse", c_spur, 1);
    chk("c_spur_viol", c_viol, 1);
    chk("c_spur_sticky", c_stk, 1);
    c_busy = 0;
    tick();
    chk("c_spur_drop", c_spur, 0);
    c_go = 3'b010;
    tick();
    tick();
    tick();
    tick();
    chk("c_sat_viol", c_viol, 3);
    chk("c_sat_trig", c_trig, 3);
    chk("c_sat_late", c_late, 1);
    c_clr = 1;
    tick();
    chk("c_clr_late", c_late, 1);
    chk("c_clr_viol", c_viol, 0);
    chk("c_clr_sticky", c_stk, 0);
    chk("c_clr_trig", c_trig, 0);
    c_clr = 0; c_go = 3'b000;
    tick();
    chk("c_post_late", c_late, 0);
    chk("c_post_viol", c_viol, 0);

    // Async reset while B waits for busy
    b_go = 3'b111;
    tick();
    chk("b_rst_pre_state", b_st, 1);
    b_go = 3'b000;
    #2;
    rst_n = 1'b0;
    #1;
    chk("b_rst_state", b_st, 0);
    chk("b_rst_cnt", {b_trig, b_viol}, 0);
    chk("b_rst_err", {b_late, b_tmo, b_spur, b_stk}, 0);
    #3;
    rst_n = 1'b1;
    tick();
    tick();
    chk("b_rst_quiet", {b_st, b_late}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
